data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-port (CPU + debug/loader) arbiter in front of a single data memory map.
//   A three-state FSM (IDLE -> ACCESS -> DONE) serves one access at a time.
//   Accesses to registers/IO and all writes complete after FAST_WAIT cycles.
//   SRAM reads (addr >= 0x0060, not IO) complete after SRAM_RD_WAIT cycles.
//   When both ports request, they are served round-robin.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   cpu_req/we/io_only/addr/wdata     CPU request side (level request)
//   cpu_gnt, cpu_done, cpu_rdata      CPU accept pulse, completion pulse, read data
//   dbg_req/we/addr/wdata             debug request side (data space only)
//   dbg_gnt, dbg_done, dbg_rdata      debug accept pulse, completion pulse, read data
//   mem_addr/we/data_in/io_only       memory map request (registered)
//   mem_q                             memory map read data
//   busy                              high whenever the FSM is not IDLE
module data_mem_arbiter #(
  parameter int unsigned SRAM_RD_WAIT = 3,
  parameter int unsigned FAST_WAIT    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_io_only,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [7:0]  cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_done,
  output logic [7:0]  dbg_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_data_in,
  output logic        mem_io_only,
  input  logic [7:0]  mem_q,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter load values are the wait count minus one: the counter reaching
  // zero marks the last ACCESS cycle.
  localparam logic [2:0]  FAST_LOAD = 3'(FAST_WAIT - 1);
  localparam logic [2:0]  SRAM_LOAD = 3'(SRAM_RD_WAIT - 1);
  localparam logic [15:0] SRAM_BASE = 16'h0060;

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic        last_dbg_r;   // 1: debug port was granted most recently
  logic        owner_dbg_r;  // 1: in-flight access belongs to debug port
  logic        read_r;       // in-flight access is a read

  logic        any_req_s;
  logic        sel_dbg_s;
  logic        sel_we_s;
  logic        sel_io_s;
  logic [15:0] sel_addr_s;
  logic [7:0]  sel_wdata_s;
  logic [2:0]  sel_load_s;

  // Only SRAM reads use the slow timing; every write, every IO access and the
  // register window below SRAM_BASE complete on the fast path.
  function automatic logic [2:0] wait_load(input logic we, input logic io,
                                           input logic [15:0] addr);
    logic [2:0] load;
    if (we || io || (addr < SRAM_BASE)) begin
      load = FAST_LOAD;
    end else begin
      load = SRAM_LOAD;
    end
    return load;
  endfunction

  // Winner selection and wait-count lookup for the request being sampled.
  always_comb begin
    any_req_s   = cpu_req | dbg_req;
    sel_dbg_s   = 1'b0;
    sel_we_s    = cpu_we;
    sel_io_s    = cpu_io_only;
    sel_addr_s  = cpu_addr;
    sel_wdata_s = cpu_wdata;
    // Debug wins when alone, or on contention when the CPU was granted last.
    if (dbg_req && (!cpu_req || !last_dbg_r)) begin
      sel_dbg_s   = 1'b1;
      sel_we_s    = dbg_we;
      sel_io_s    = 1'b0;
      sel_addr_s  = dbg_addr;
      sel_wdata_s = dbg_wdata;
    end else begin
      sel_dbg_s   = 1'b0;
    end
    sel_load_s = wait_load(sel_we_s, sel_io_s, sel_addr_s);
  end

  // Arbitration FSM with registered handshake and memory-map outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      last_dbg_r  <= 1'b1;
      owner_dbg_r <= 1'b0;
      read_r      <= 1'b0;
      cpu_gnt     <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_rdata   <= 8'h00;
      dbg_gnt     <= 1'b0;
      dbg_done    <= 1'b0;
      dbg_rdata   <= 8'h00;
      mem_addr    <= 16'h0000;
      mem_we      <= 1'b0;
      mem_data_in <= 8'h00;
      mem_io_only <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Pulses default low; mem_we is only ever high in the first ACCESS cycle.
      cpu_gnt  <= 1'b0;
      dbg_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      mem_we   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r     <= ACCESS;
            busy        <= 1'b1;
            cnt_r       <= sel_load_s;
            last_dbg_r  <= sel_dbg_s;
            owner_dbg_r <= sel_dbg_s;
            read_r      <= ~sel_we_s;
            mem_addr    <= sel_addr_s;
            mem_we      <= sel_we_s;
            mem_data_in <= sel_wdata_s;
            mem_io_only <= sel_io_s;
            if (sel_dbg_s) begin
              dbg_gnt <= 1'b1;
            end else begin
              cpu_gnt <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_r == 3'd0) begin
            if (read_r) begin
              if (owner_dbg_r) begin
                dbg_rdata <= mem_q;
              end else begin
                cpu_rdata <= mem_q;
              end
            end
            if (owner_dbg_r) begin
              dbg_done <= 1'b1;
            end else begin
              cpu_done <= 1'b1;
            end
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        DONE: begin
          // Requests are ignored here; a held request re-arbitrates in IDLE.
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Self-checking bench for data_mem_arbiter (default parameters: SRAM_RD_WAIT=3,
//   FAST_WAIT=1). A behavioural memory returns a data pattern derived from the
//   address (optionally salted with the cycle number). Expected transactions are
//   pushed to a scoreboard queue when stimulus is issued and popped on completion.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_io_only;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_done;
  logic [7:0]  cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_gnt, dbg_done;
  logic [7:0]  dbg_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_data_in;
  logic        mem_io_only;
  logic [7:0]  mem_q;
  logic        busy;

  int cyc = 0;
  bit salt_en = 1'b0;
  int assertions = 0;
  int failures = 0;

  typedef struct {
    bit         dbg;
    bit         chk_rd;
    logic [7:0] rd;
    int         gnt_cyc;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5F;
  endfunction

  assign mem_q = mem_model(mem_addr) ^ (salt_en ? cyc[7:0] : 8'h00);

  data_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_io_only(cpu_io_only),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_data_in),
    .mem_io_only(mem_io_only), .mem_q(mem_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle index; the value seen at a negedge names the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Issues one access on a single port starting at the current negedge and
  // observes it to completion; scrambles the port inputs once granted.
  task automatic run_access(input bit dbg, input bit we, input bit io,
                            input logic [15:0] addr, input logic [7:0] wd,
                            output int g_cyc, output int d_cyc, output logic [7:0] rd,
                            output int we_cnt, output bit io_seen, output bit addr_bad,
                            output bit data_bad, output bit other_bad);
    logic [7:0] other_rd0;
    bit got_g;
    logic dn;
    g_cyc = -1; d_cyc = -1; rd = 8'h00; we_cnt = 0; io_seen = 1'b0;
    addr_bad = 1'b0; data_bad = 1'b0; other_bad = 1'b0; got_g = 1'b0;
    other_rd0 = dbg ? cpu_rdata : dbg_rdata;
    if (dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_io_only = io; cpu_addr = addr; cpu_wdata = wd;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dbg ? (cpu_gnt | cpu_done | (cpu_rdata !== other_rd0))
              : (dbg_gnt | dbg_done | (dbg_rdata !== other_rd0))) other_bad = 1'b1;
      if (dbg ? dbg_gnt : cpu_gnt) begin
        g_cyc = cyc; got_g = 1'b1;
      end
      dn = dbg ? dbg_done : cpu_done;
      if (mem_we) begin
        we_cnt++;
        if (mem_addr !== addr || mem_data_in !== wd) data_bad = 1'b1;
      end
      if (got_g && !dn) begin
        if (mem_addr !== addr) addr_bad = 1'b1;
        io_seen = io_seen | mem_io_only;
      end
      if (dn) begin
        d_cyc = cyc; rd = dbg ? dbg_rdata : cpu_rdata;
        break;
      end
      if (got_g) begin
        if (dbg) begin
          dbg_addr = addr ^ 16'hFFFF; dbg_wdata = ~wd; dbg_we = ~we;
        end else begin
          cpu_addr = addr ^ 16'hFFFF; cpu_wdata = ~wd; cpu_we = ~we; cpu_io_only = ~io;
        end
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_io_only = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0000; dbg_wdata = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    cpu_req = 1'b1; dbg_req = 1'b1;
    repeat (2) @(negedge clk);
    assertions++;
    if ({cpu_gnt, cpu_done, cpu_rdata, dbg_gnt, dbg_done, dbg_rdata} !== 20'h0) begin
      failures++;
      $display("FAIL reset_handshake: got %05h exp 00000",
               {cpu_gnt, cpu_done, cpu_rdata, dbg_gnt, dbg_done, dbg_rdata});
    end
    assertions++;
    if ({mem_addr, mem_we, mem_data_in, mem_io_only} !== 26'h0) begin
      failures++;
      $display("FAIL reset_mem: got %07h exp 0000000", {mem_addr, mem_we, mem_data_in, mem_io_only});
    end
    assertions++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b exp 0", busy);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_reg_read();
    exp_t e; int g, d, wc; logic [7:0] rd; bit io, ab, db, ob;
    e = '{dbg: 1'b0, chk_rd: 1'b1, rd: 8'h5A, gnt_cyc: cyc + 1, done_cyc: cyc + 2};
    sb.push_back(e);
    run_access(1'b0, 1'b0, 1'b0, 16'h0005, 8'h00, g, d, rd, wc, io, ab, db, ob);
    e = sb.pop_front();
    assertions++;
    if (g !== e.gnt_cyc) begin failures++; $display("FAIL cpu_rd_gnt: got %0d exp %0d", g, e.gnt_cyc); end
    assertions++;
    if (d !== e.done_cyc) begin failures++; $display("FAIL cpu_rd_done: got %0d exp %0d", d, e.done_cyc); end
    assertions++;
    if (rd !== e.rd) begin failures++; $display("FAIL cpu_rd_data: got %02h exp %02h", rd, e.rd); end
    assertions++;
    if (wc !== 0) begin failures++; $display("FAIL cpu_rd_no_we: got %0d exp 0", wc); end
    assertions++;
    if (ab || ob) begin failures++; $display("FAIL cpu_rd_stable: addr_bad %b other_bad %b exp 0 0", ab, ob); end
  endtask

  task automatic test_cpu_write();
    exp_t e; int g, d, wc; logic [7:0] rd; bit io, ab, db, ob;
    // Write leaves cpu_rdata holding the previous read value.
    e = '{dbg: 1'b0, chk_rd: 1'b1, rd: 8'h5A, gnt_cyc: cyc + 1, done_cyc: cyc + 2};
    sb.push_back(e);
    run_access(1'b0, 1'b1, 1'b0, 16'h0100, 8'hC3, g, d, rd, wc, io, ab, db, ob);
    e = sb.pop_front();
    assertions++;
    if (wc !== 1) begin failures++; $display("FAIL cpu_wr_we_cycles: got %0d exp 1", wc); end
    assertions++;
    if (db) begin failures++; $display("FAIL cpu_wr_addr_data: got bad exp mem_addr 0100 data c3"); end
    assertions++;
    if (d !== e.done_cyc || g !== e.gnt_cyc) begin
      failures++; $display("FAIL cpu_wr_timing: got gnt %0d done %0d exp %0d %0d", g, d, e.gnt_cyc, e.done_cyc);
    end
    assertions++;
    if (rd !== e.rd) begin failures++; $display("FAIL cpu_wr_rdata_hold: got %02h exp %02h", rd, e.rd); end
  endtask

  task automatic test_dbg_sram_read();
    exp_t e; int g, d, wc, c; logic [7:0] rd; bit io, ab, db, ob;
    c = cyc;
    salt_en = 1'b1;
    // Data captured during the last ACCESS cycle, which is cycle c+3.
    e = '{dbg: 1'b1, chk_rd: 1'b1, rd: mem_model(16'h0200) ^ 8'(c + 3),
          gnt_cyc: c + 1, done_cyc: c + 4};
    sb.push_back(e);
    run_access(1'b1, 1'b0, 1'b0, 16'h0200, 8'h00, g, d, rd, wc, io, ab, db, ob);
    salt_en = 1'b0;
    e = sb.pop_front();
    assertions++;
    if (g !== e.gnt_cyc) begin failures++; $display("FAIL dbg_sram_gnt: got %0d exp %0d", g, e.gnt_cyc); end
    assertions++;
    if (d !== e.done_cyc) begin failures++; $display("FAIL dbg_sram_done: got %0d exp %0d", d, e.done_cyc); end
    assertions++;
    if (rd !== e.rd) begin failures++; $display("FAIL dbg_sram_data: got %02h exp %02h", rd, e.rd); end
    assertions++;
    if (io !== 1'b0 || ab) begin failures++; $display("FAIL dbg_sram_bus: io %b addr_bad %b exp 0 0", io, ab); end
    assertions++;
    if (ob) begin failures++; $display("FAIL dbg_sram_cpu_side: got changed exp unchanged"); end
  endtask

  typedef struct {
    bit          dbg;
    bit          we;
    bit          io;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          w;
  } vec_t;

  task automatic test_wait_classes();
    vec_t v[8];
    exp_t e; int g, d, wc; logic [7:0] rd; bit io, ab, db, ob;
    v[0] = '{dbg: 1'b0, we: 1'b1, io: 1'b1, addr: 16'h003F, wd: 8'h11, w: 1};
    v[1] = '{dbg: 1'b0, we: 1'b0, io: 1'b0, addr: 16'h005F, wd: 8'h00, w: 1};
    v[2] = '{dbg: 1'b0, we: 1'b0, io: 1'b0, addr: 16'h0060, wd: 8'h00, w: 3};
    v[3] = '{dbg: 1'b1, we: 1'b0, io: 1'b0, addr: 16'h005F, wd: 8'h00, w: 1};
    v[4] = '{dbg: 1'b1, we: 1'b1, io: 1'b0, addr: 16'h0700, wd: 8'h96, w: 1};
    v[5] = '{dbg: 1'b0, we: 1'b0, io: 1'b0, addr: 16'h1234, wd: 8'h00, w: 3};
    v[6] = '{dbg: 1'b0, we: 1'b0, io: 1'b1, addr: 16'h1000, wd: 8'h00, w: 1};
    v[7] = '{dbg: 1'b1, we: 1'b0, io: 1'b0, addr: 16'hFFFF, wd: 8'h00, w: 3};
    for (int i = 0; i < 8; i++) begin
      e = '{dbg: v[i].dbg, chk_rd: ~v[i].we, rd: mem_model(v[i].addr),
            gnt_cyc: cyc + 1, done_cyc: cyc + 1 + v[i].w};
      sb.push_back(e);
      run_access(v[i].dbg, v[i].we, v[i].io, v[i].addr, v[i].wd, g, d, rd, wc, io, ab, db, ob);
      e = sb.pop_front();
      assertions++;
      if (g !== e.gnt_cyc || d !== e.done_cyc) begin
        failures++;
        $display("FAIL wait_class[%0d] timing: got gnt %0d done %0d exp %0d %0d", i, g, d, e.gnt_cyc, e.done_cyc);
      end
      if (e.chk_rd) begin
        assertions++;
        if (rd !== e.rd) begin failures++; $display("FAIL wait_class[%0d] rdata: got %02h exp %02h", i, rd, e.rd); end
      end
      assertions++;
      if (wc !== int'(v[i].we) || db) begin
        failures++; $display("FAIL wait_class[%0d] we: got %0d cycles bad %b exp %0d 0", i, wc, db, v[i].we);
      end
      assertions++;
      if (io !== (v[i].io & ~v[i].dbg) || ab || ob) begin
        failures++;
        $display("FAIL wait_class[%0d] bus: io %b addr_bad %b other %b exp %b 0 0", i, io, ab, ob, v[i].io & ~v[i].dbg);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e; int c; int gnt_at[$]; bit gnt_dbg[$]; int done_at[$]; logic [7:0] done_rd[$];
    bit both;
    both = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    // Release reset and request on both ports in the same cycle.
    reset_n = 1'b1;
    cpu_req = 1'b1; cpu_addr = 16'h0010; dbg_req = 1'b1; dbg_addr = 16'h0010;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      e = '{dbg: (i % 2) == 1, chk_rd: 1'b1, rd: mem_model(16'h0010),
            gnt_cyc: c + 1 + 3 * i, done_cyc: c + 2 + 3 * i};
      sb.push_back(e);
    end
    for (int k = 0; k < 40 && done_at.size() < 4; k++) begin
      @(negedge clk);
      if (cpu_gnt && dbg_gnt) both = 1'b1;
      if (cpu_gnt || dbg_gnt) begin gnt_at.push_back(cyc); gnt_dbg.push_back(dbg_gnt); end
      if (cpu_done) begin done_at.push_back(cyc); done_rd.push_back(cpu_rdata); end
      if (dbg_done) begin done_at.push_back(cyc); done_rd.push_back(dbg_rdata); end
    end
    cpu_req = 1'b0; dbg_req = 1'b0; cpu_addr = 16'h0000; dbg_addr = 16'h0000;
    repeat (2) @(negedge clk);
    assertions++;
    if (both || done_at.size() != 4 || gnt_at.size() < 4) begin
      failures++;
      $display("FAIL rr_count: got grants %0d dones %0d dual %b exp >=4 4 0", gnt_at.size(), done_at.size(), both);
      sb.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = sb.pop_front();
        assertions++;
        if (gnt_dbg[i] !== e.dbg || gnt_at[i] !== e.gnt_cyc || done_at[i] !== e.done_cyc || done_rd[i] !== e.rd) begin
          failures++;
          $display("FAIL rr_grant[%0d]: got dbg %b gnt %0d done %0d rd %02h exp dbg %b gnt %0d done %0d rd %02h",
                   i, gnt_dbg[i], gnt_at[i], done_at[i], done_rd[i], e.dbg, e.gnt_cyc, e.done_cyc, e.rd);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e; int g, d, wc; logic [7:0] rd; bit io, ab, db, ob, seen, late;
    // SRAM read abandoned in its second ACCESS cycle.
    seen = 1'b0; late = 1'b0;
    dbg_req = 1'b1; dbg_addr = 16'h0300;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = dbg_gnt;
    end
    @(negedge clk);
    assertions++;
    if (!seen || busy !== 1'b1) begin failures++; $display("FAIL rst_mid_pre: gnt %b busy %b exp 1 1", seen, busy); end
    reset_n = 1'b0;
    #1;
    assertions++;
    if ({busy, mem_we, dbg_done, cpu_done, dbg_rdata} !== 12'h000) begin
      failures++;
      $display("FAIL rst_mid_outputs: got busy %b we %b done %b/%b rd %02h exp all 0",
               busy, mem_we, dbg_done, cpu_done, dbg_rdata);
    end
    dbg_req = 1'b0; dbg_addr = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dbg_done || cpu_done || busy) late = 1'b1;
    end
    assertions++;
    if (late) begin failures++; $display("FAIL rst_mid_no_done: got activity exp none"); end
    // Write abandoned while mem_we is high.
    seen = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'hC3;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = cpu_gnt;
    end
    assertions++;
    if (!seen || mem_we !== 1'b1) begin failures++; $display("FAIL rst_wr_pre: gnt %b we %b exp 1 1", seen, mem_we); end
    reset_n = 1'b0;
    #1;
    assertions++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_wr_we: got %b exp 0", mem_we); end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // Normal service afterwards.
    e = '{dbg: 1'b0, chk_rd: 1'b1, rd: mem_model(16'h0040), gnt_cyc: cyc + 1, done_cyc: cyc + 2};
    sb.push_back(e);
    run_access(1'b0, 1'b0, 1'b0, 16'h0040, 8'h00, g, d, rd, wc, io, ab, db, ob);
    e = sb.pop_front();
    assertions++;
    if (g !== e.gnt_cyc || d !== e.done_cyc || rd !== e.rd) begin
      failures++;
      $display("FAIL rst_recover: got gnt %0d done %0d rd %02h exp %0d %0d %02h", g, d, rd, e.gnt_cyc, e.done_cyc, e.rd);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_io_only = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0000; dbg_wdata = 8'h00;
    test_reset();
    test_cpu_reg_read();
    test_cpu_write();
    test_dbg_sram_read();
    test_wait_classes();
    test_round_robin();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
